// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per clock under a start/done handshake.
// Optional SIGNED_DIV_EN: two's-complement operands with a sign fix-up cycle before done.
module seq_divider #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] r,
   output logic             dbz,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX, FIN} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   rem_ext;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] dvd_nxt;

`ifdef SIGNED_DIV_EN
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   logic             neg_q_q, neg_q_d;
   logic             neg_r_q, neg_r_d;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;
`endif

   // Dividend register doubles as the quotient: each shift pulls in the next quotient bit.
   assign rem_ext = {rem_q, dvd_q[WIDTH-1]};
   assign trial   = rem_ext - {1'b0, dvs_q};
   assign rem_nxt = trial[WIDTH] ? rem_ext[WIDTH-1:0] : trial[WIDTH-1:0];
   assign dvd_nxt = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      ovf_d   = ovf_q;
`ifdef SIGNED_DIV_EN
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dbz_d = 1'b0;
               ovf_d = 1'b0;
               if (b == '0) begin
                  q_d     = '1;
                  r_d     = a;
                  dbz_d   = 1'b1;
                  state_d = FIN;
               end
`ifdef SIGNED_DIV_EN
               else if ((a == MOST_NEG) && (b == '1)) begin
                  q_d     = MOST_NEG;
                  r_d     = '0;
                  ovf_d   = 1'b1;
                  state_d = FIN;
               end
`endif
               else begin
`ifdef SIGNED_DIV_EN
                  dvd_d   = a_mag;
                  dvs_d   = b_mag;
                  neg_q_d = a[WIDTH-1] ^ b[WIDTH-1];
                  neg_r_d = a[WIDTH-1];
`else
                  dvd_d   = a;
                  dvs_d   = b;
`endif
                  rem_d   = '0;
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d = rem_nxt;
            dvd_d = dvd_nxt;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
`ifdef SIGNED_DIV_EN
               state_d = FIX;
`else
               q_d     = dvd_nxt;
               r_d     = rem_nxt;
               state_d = FIN;
`endif
            end
         end
`ifdef SIGNED_DIV_EN
         FIX: begin
            q_d     = neg_q_q ? -dvd_q : dvd_q;
            r_d     = neg_r_q ? -rem_q : rem_q;
            state_d = FIN;
         end
`endif
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
         ovf_q   <= ovf_d;
`ifdef SIGNED_DIV_EN
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
`endif
      end
   end

   assign busy = (state_q == RUN) || (state_q == FIX);
   assign done = (state_q == FIN);
   assign q    = q_q;
   assign r    = r_q;
   assign dbz  = dbz_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=4; inputs driven and outputs sampled on the falling edge.
module tb_seq_divider;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [3:0] q;
   logic [3:0] r;
   logic       dbz;
   logic       ovf;

   int n_cmp;
   int n_err;

   seq_divider #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .q     (q),
      .r     (r),
      .dbz   (dbz),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Latency counts falling edges after the start edge up to the first one that sees done.
   task automatic launch(input logic [3:0] av, input logic [3:0] bv,
                         output int lat, output logic busy1);
      @(negedge clk);
      a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; a = ~av; b = ~bv;
      lat = 0; busy1 = 1'b0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (lat == 1) busy1 = busy;
         if (done) break;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      #1;
      n_cmp++;
      if ({busy, done, q, r, dbz, ovf} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_held: got %b want 000000000000", {busy, done, q, r, dbz, ovf});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({busy, done, q, r, dbz, ovf} !== 12'h000) begin
         n_err++;
         $display("FAIL reset_released: got %b want 000000000000", {busy, done, q, r, dbz, ovf});
      end
   endtask

   task automatic test_basic;
      int lat; logic b1;
      launch(4'd13, 4'd3, lat, b1);
      n_cmp++;
      if (lat !== 5) begin n_err++; $display("FAIL 13/3 latency: got %0d want 5", lat); end
      n_cmp++;
      if (b1 !== 1'b1) begin n_err++; $display("FAIL 13/3 busy: got %b want 1", b1); end
      n_cmp++;
      if ({q, r} !== {4'd4, 4'd1}) begin
         n_err++; $display("FAIL 13/3 q,r: got %0d,%0d want 4,1", q, r);
      end
      n_cmp++;
      if ({dbz, ovf, busy} !== 3'b000) begin
         n_err++; $display("FAIL 13/3 flags dbz,ovf,busy: got %b want 000", {dbz, ovf, busy});
      end
      @(negedge clk);
      n_cmp++;
      if ({done, busy, q} !== {2'b00, 4'd4}) begin
         n_err++; $display("FAIL 13/3 after_done done,busy,q: got %b want 000100", {done, busy, q});
      end
   endtask

   task automatic test_back_to_back;
      int lat; logic b1;
      launch(4'd15, 4'd1, lat, b1);
      n_cmp++;
      if ({q, r} !== {4'd15, 4'd0}) begin
         n_err++; $display("FAIL 15/1 q,r: got %0d,%0d want 15,0", q, r);
      end
      launch(4'd3, 4'd7, lat, b1);
      n_cmp++;
      if (lat !== 5) begin n_err++; $display("FAIL b2b 3/7 latency: got %0d want 5", lat); end
      n_cmp++;
      if ({q, r} !== {4'd0, 4'd3}) begin
         n_err++; $display("FAIL b2b 3/7 q,r: got %0d,%0d want 0,3", q, r);
      end
   endtask

   task automatic test_div_zero;
      int lat; logic b1;
      launch(4'd5, 4'd0, lat, b1);
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL 5/0 latency: got %0d want 1", lat); end
      n_cmp++;
      if ({q, r, dbz, ovf, b1} !== {4'd15, 4'd5, 3'b100}) begin
         n_err++;
         $display("FAIL 5/0 q,r,dbz,ovf,busy: got %0d,%0d,%b%b%b want 15,5,100", q, r, dbz, ovf, b1);
      end
      launch(4'd8, 4'd4, lat, b1);
      n_cmp++;
      if ({q, r, dbz} !== {4'd2, 4'd0, 1'b0}) begin
         n_err++; $display("FAIL 8/4 q,r,dbz: got %0d,%0d,%b want 2,0,0", q, r, dbz);
      end
   endtask

   task automatic test_ignore_start;
      int lat;
      @(negedge clk);
      a = 4'd12; b = 4'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      a = 4'd1; b = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (lat < 20 && !done) begin
         @(negedge clk);
         lat++;
      end
      n_cmp++;
      if (lat !== 5) begin n_err++; $display("FAIL 12/5 latency: got %0d want 5", lat); end
      n_cmp++;
      if ({q, r} !== {4'd2, 4'd2}) begin
         n_err++; $display("FAIL 12/5 ignored_start q,r: got %0d,%0d want 2,2", q, r);
      end
      @(negedge clk);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_err++; $display("FAIL 12/5 no_restart busy,done: got %b want 00", {busy, done});
      end
   endtask

`ifdef SIGNED_DIV_EN
   task automatic test_signed;
      int lat; logic b1;
      launch(4'b1001, 4'd2, lat, b1);
      n_cmp++;
      if (lat !== 6) begin n_err++; $display("FAIL -7/2 latency: got %0d want 6", lat); end
      n_cmp++;
      if ({q, r} !== {4'b1101, 4'b1111}) begin
         n_err++; $display("FAIL -7/2 q,r: got %b,%b want 1101,1111", q, r);
      end
      launch(4'b1000, 4'b1111, lat, b1);
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL -8/-1 latency: got %0d want 1", lat); end
      n_cmp++;
      if ({q, r, dbz, ovf} !== {4'b1000, 4'b0000, 2'b01}) begin
         n_err++; $display("FAIL -8/-1 q,r,dbz,ovf: got %b,%b,%b%b want 1000,0000,01", q, r, dbz, ovf);
      end
      launch(4'd7, 4'b1110, lat, b1);
      n_cmp++;
      if ({q, r, ovf} !== {4'b1101, 4'b0001, 1'b0}) begin
         n_err++; $display("FAIL 7/-2 q,r,ovf: got %b,%b,%b want 1101,0001,0", q, r, ovf);
      end
   endtask
`endif

   task automatic test_abort;
      logic seen;
      @(negedge clk);
      a = 4'd9; b = 4'd2; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin n_err++; $display("FAIL abort pre busy: got %b want 1", busy); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, q, r, dbz, ovf} !== 12'h000) begin
         n_err++;
         $display("FAIL abort async_clear: got %b want 000000000000", {busy, done, q, r, dbz, ovf});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin n_err++; $display("FAIL abort no_done: got %b want 0", seen); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
`ifdef SIGNED_DIV_EN
      test_signed();
`else
      test_basic();
      test_back_to_back();
      test_div_zero();
      test_ignore_start();
`endif
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
